// File: rtl/exec_result_pipe_pkg.sv
// Shared opcode package for the execution result pipe.
// Holds the producing-unit identifiers and the field-offset helpers that
// describe the per-stage packet layout {valid, unit_id, result, reg_dst,
// latency, reg_wr}, with reg_wr in bit 0 and valid in the MSB.
package exec_result_pipe_pkg;

    // Producing unit identifiers
    localparam logic [2:0] UNIT_PERM   = 3'b100;
    localparam logic [2:0] UNIT_LS     = 3'b101;
    localparam logic [2:0] UNIT_BRANCH = 3'b110;

    // Total packet width for the given field widths
    function automatic int pack_width(input int unit_w, input int data_w,
                                      input int reg_addr_w, input int lat_w);
        return 2 + unit_w + data_w + reg_addr_w + lat_w;
    endfunction

    // Bit offset of the register-write flag
    function automatic int off_reg_wr();
        return 0;
    endfunction

    // Bit offset of the latency field
    function automatic int off_latency();
        return 1;
    endfunction

    // Bit offset of the destination register field
    function automatic int off_reg_dst(input int lat_w);
        return 1 + lat_w;
    endfunction

    // Bit offset of the result field
    function automatic int off_result(input int lat_w, input int reg_addr_w);
        return 1 + lat_w + reg_addr_w;
    endfunction

    // Bit offset of the unit id field
    function automatic int off_unit_id(input int lat_w, input int reg_addr_w,
                                       input int data_w);
        return 1 + lat_w + reg_addr_w + data_w;
    endfunction

    // Bit offset of the valid flag (packet MSB)
    function automatic int off_valid(input int unit_w, input int data_w,
                                     input int reg_addr_w, input int lat_w);
        return 1 + lat_w + reg_addr_w + data_w + unit_w;
    endfunction

endpackage

// File: rtl/exec_result_pipe_stage.sv
// exec_pipe_stage: one stall-able packet register of the result pipe.
// Loads d when en is high, otherwise holds; cleared by asynchronous rst.
module exec_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Packet register: clear on reset, load when enabled, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/exec_result_pipe.sv
// exec_result_pipe: fixed-depth execution result pipeline.
// Each issue-slot packet shifts through DEPTH stages; every stage reports
// whether its result may be forwarded, and the last stage feeds a registered
// writeback port. A stall freezes the whole pipe and suppresses writeback.
// Optional feature: define EXEC_RESULT_PIPE_LATCHK_EN to add the sticky
// lat_err output flagging issued latencies outside 1..DEPTH.
module exec_result_pipe
    import exec_result_pipe_pkg::*;
#(
    parameter int DEPTH      = 7,
    parameter int DATA_W     = 128,
    parameter int REG_ADDR_W = 7,
    parameter int UNIT_W     = 3,
    parameter int LAT_W      = 4,
    localparam int PACK_W    = 2 + UNIT_W + DATA_W + REG_ADDR_W + LAT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [UNIT_W-1:0]       in_unit_id,
    input  logic [DATA_W-1:0]       in_result,
    input  logic [REG_ADDR_W-1:0]   in_reg_dst,
    input  logic [LAT_W-1:0]        in_latency,
    input  logic                    in_reg_wr,
    input  logic                    stall,
    input  logic                    flush,
    output logic [DEPTH*PACK_W-1:0] stage_pack,
    output logic [DEPTH-1:0]        fwd_valid,
    output logic                    wb_en,
    output logic [REG_ADDR_W-1:0]   wb_addr,
    output logic [DATA_W-1:0]       wb_data,
    output logic [LAT_W-1:0]        occupancy
`ifdef EXEC_RESULT_PIPE_LATCHK_EN
    ,
    output logic                    lat_err
`endif
);

    // Packet layout offsets from the shared package
    localparam int OFF_REG_WR  = off_reg_wr();
    localparam int OFF_LAT     = off_latency();
    localparam int OFF_DST     = off_reg_dst(LAT_W);
    localparam int OFF_RES     = off_result(LAT_W, REG_ADDR_W);
    localparam int OFF_VALID   = off_valid(UNIT_W, DATA_W, REG_ADDR_W, LAT_W);
    localparam logic [LAT_W-1:0] DEPTH_L = LAT_W'(DEPTH);

    logic [PACK_W-1:0] stage_d_s [DEPTH];
    logic [PACK_W-1:0] stage_q_s [DEPTH];
    logic              shift_en_s;
    logic              cap_valid_s;
    logic              last_valid_s;
    logic              last_wr_s;
    logic [LAT_W-1:0]  occ_next_s;

    assign shift_en_s   = ~stall;
    // Flush only kills the packet being captured; other fields pass unchanged
    assign cap_valid_s  = in_valid & ~flush;
    assign last_valid_s = stage_q_s[DEPTH-1][OFF_VALID];
    assign last_wr_s    = stage_q_s[DEPTH-1][OFF_REG_WR];

    // Stage 1 input is the issue-slot packet; stage k+1 input is stage k
    assign stage_d_s[0] = {cap_valid_s, in_unit_id, in_result, in_reg_dst,
                           in_latency, in_reg_wr};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_stage
            localparam logic [LAT_W:0] STAGE_NUM = (LAT_W+1)'(gi + 1);
            logic [LAT_W:0] lat_ext_s;

            if (gi > 0) begin : g_link
                assign stage_d_s[gi] = stage_q_s[gi-1];
            end

            exec_pipe_stage #(
                .W (PACK_W)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (shift_en_s),
                .d   (stage_d_s[gi]),
                .q   (stage_q_s[gi])
            );

            // Stage 1 occupies the MSB end of the flat bus
            assign stage_pack[(DEPTH-1-gi)*PACK_W +: PACK_W] = stage_q_s[gi];

            // Forward-eligible once the stage number reaches the packet latency
            assign lat_ext_s     = {1'b0, stage_q_s[gi][OFF_LAT +: LAT_W]};
            assign fwd_valid[gi] = stage_q_s[gi][OFF_VALID] &
                                   stage_q_s[gi][OFF_REG_WR] &
                                   (lat_ext_s <= STAGE_NUM);
        end
    endgenerate

    // Next occupancy: +1 on a valid capture, -1 when the last stage drains, saturating
    always_comb begin
        occ_next_s = occupancy;
        if (cap_valid_s && !last_valid_s) begin
            if (occupancy >= DEPTH_L) begin
                occ_next_s = DEPTH_L;
            end else begin
                occ_next_s = occupancy + LAT_W'(1);
            end
        end else if (!cap_valid_s && last_valid_s) begin
            if (occupancy == {LAT_W{1'b0}}) begin
                occ_next_s = {LAT_W{1'b0}};
            end else begin
                occ_next_s = occupancy - LAT_W'(1);
            end
        end else begin
            occ_next_s = occupancy;
        end
    end

    // Occupancy register, frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= {LAT_W{1'b0}};
        end else if (!stall) begin
            occupancy <= occ_next_s;
        end else begin
            occupancy <= occupancy;
        end
    end

    // Writeback register from the last stage; a stall drops wb_en and holds address/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= {REG_ADDR_W{1'b0}};
            wb_data <= {DATA_W{1'b0}};
        end else if (stall) begin
            wb_en   <= 1'b0;
            wb_addr <= wb_addr;
            wb_data <= wb_data;
        end else begin
            wb_en   <= last_valid_s & last_wr_s;
            wb_addr <= stage_q_s[DEPTH-1][OFF_DST +: REG_ADDR_W];
            wb_data <= stage_q_s[DEPTH-1][OFF_RES +: DATA_W];
        end
    end

`ifdef EXEC_RESULT_PIPE_LATCHK_EN
    logic lat_bad_s;

    // Issued latency outside 1..DEPTH (flush does not excuse it)
    assign lat_bad_s = in_valid &
                       ((in_latency == {LAT_W{1'b0}}) || (in_latency > DEPTH_L));

    // Sticky latency error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_err <= 1'b0;
        end else if (!stall && lat_bad_s) begin
            lat_err <= 1'b1;
        end else begin
            lat_err <= lat_err;
        end
    end
`endif

endmodule

// File: tb/tb_exec_result_pipe.sv
// Directed testbench for exec_result_pipe (default parameters).
// The lat_err checks are compiled in only with EXEC_RESULT_PIPE_LATCHK_EN.
module tb_exec_result_pipe;
    import exec_result_pipe_pkg::*;

    localparam int DEPTH      = 7;
    localparam int DATA_W     = 128;
    localparam int REG_ADDR_W = 7;
    localparam int UNIT_W     = 3;
    localparam int LAT_W      = 4;
    localparam int PACK_W     = 2 + UNIT_W + DATA_W + REG_ADDR_W + LAT_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [UNIT_W-1:0]       in_unit_id;
    logic [DATA_W-1:0]       in_result;
    logic [REG_ADDR_W-1:0]   in_reg_dst;
    logic [LAT_W-1:0]        in_latency;
    logic                    in_reg_wr;
    logic                    stall;
    logic                    flush;
    logic [DEPTH*PACK_W-1:0] stage_pack;
    logic [DEPTH-1:0]        fwd_valid;
    logic                    wb_en;
    logic [REG_ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]       wb_data;
    logic [LAT_W-1:0]        occupancy;
`ifdef EXEC_RESULT_PIPE_LATCHK_EN
    logic                    lat_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    exec_result_pipe #(
        .DEPTH      (DEPTH),
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .UNIT_W     (UNIT_W),
        .LAT_W      (LAT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_unit_id (in_unit_id),
        .in_result  (in_result),
        .in_reg_dst (in_reg_dst),
        .in_latency (in_latency),
        .in_reg_wr  (in_reg_wr),
        .stall      (stall),
        .flush      (flush),
        .stage_pack (stage_pack),
        .fwd_valid  (fwd_valid),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .occupancy  (occupancy)
`ifdef EXEC_RESULT_PIPE_LATCHK_EN
        ,
        .lat_err    (lat_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got,
                         input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [REG_ADDR_W-1:0] dst,
                         input logic [LAT_W-1:0] lat, input logic wr,
                         input logic [DATA_W-1:0] res);
        in_valid   = v;
        in_reg_dst = dst;
        in_latency = lat;
        in_reg_wr  = wr;
        in_result  = res;
    endtask

    // Stage k (1-based) packet, stage 1 at the MSB end
    function automatic logic [PACK_W-1:0] stg(input int k);
        return stage_pack[(DEPTH-k)*PACK_W +: PACK_W];
    endfunction

    function automatic logic stg_valid(input int k);
        logic [PACK_W-1:0] p;
        p = stg(k);
        return p[PACK_W-1];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] stg_dst(input int k);
        logic [PACK_W-1:0] p;
        p = stg(k);
        return p[1+LAT_W +: REG_ADDR_W];
    endfunction

    function automatic logic [LAT_W-1:0] stg_lat(input int k);
        logic [PACK_W-1:0] p;
        p = stg(k);
        return p[1 +: LAT_W];
    endfunction

    function automatic logic [UNIT_W-1:0] stg_unit(input int k);
        logic [PACK_W-1:0] p;
        p = stg(k);
        return p[PACK_W-2 -: UNIT_W];
    endfunction

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        in_unit_id = UNIT_PERM;
        issue(1'b0, 7'd0, 4'd0, 1'b0, 128'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_pack", 160'(|stage_pack), 160'd0);
        check("rst_fwd", 160'(fwd_valid), 160'd0);
        check("rst_wb_en", 160'(wb_en), 160'd0);
        check("rst_wb_addr", 160'(wb_addr), 160'd0);
        check("rst_wb_data", 160'(wb_data), 160'd0);
        check("rst_occ", 160'(occupancy), 160'd0);
`ifdef EXEC_RESULT_PIPE_LATCHK_EN
        check("rst_lat_err", 160'(lat_err), 160'd0);
`endif
        rst = 1'b0;
        step();

        // Single issue, latency 3
        in_unit_id = UNIT_LS;
        issue(1'b1, 7'd5, 4'd3, 1'b1, {16{8'hA5}});
        step();
        in_valid = 1'b0;
        check("single_unit", 160'(stg_unit(1)), 160'(UNIT_LS));
        check("single_occ", 160'(occupancy), 160'd1);
        for (int s = 1; s <= DEPTH; s++) begin
            logic [DEPTH-1:0] ef;
            ef = (s >= 3) ? DEPTH'(1 << (s - 1)) : '0;
            check($sformatf("single_fwd_s%0d", s), 160'(fwd_valid), 160'(ef));
            check($sformatf("single_nowb_s%0d", s), 160'(wb_en), 160'd0);
            step();
        end
        check("single_wb_en", 160'(wb_en), 160'd1);
        check("single_wb_addr", 160'(wb_addr), 160'd5);
        check("single_wb_data", 160'(wb_data), 160'({16{8'hA5}}));
        check("single_occ_end", 160'(occupancy), 160'd0);
        step();
        check("single_wb_once", 160'(wb_en), 160'd0);

        // Back-to-back issue: occupancy climbs and saturates, writebacks in order
        in_unit_id = UNIT_BRANCH;
        for (int i = 1; i <= 16; i++) begin
            int eo;
            if (i <= 9) issue(1'b1, 7'(i), 4'd1, 1'b1, 128'(i));
            else in_valid = 1'b0;
            step();
            eo = (i <= 7) ? i : ((i <= 9) ? 7 : 16 - i);
            check($sformatf("b2b_occ_%0d", i), 160'(occupancy), 160'(eo));
            if (i >= 8) begin
                check($sformatf("b2b_wb_en_%0d", i), 160'(wb_en), 160'd1);
                check($sformatf("b2b_wb_addr_%0d", i), 160'(wb_addr), 160'(i - 7));
            end
        end
        step();
        check("b2b_drained", 160'(wb_en), 160'd0);

        // Stall for 3 cycles with 4 entries in flight
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 7'(11 + i), 4'd2, 1'b1, 128'(11 + i));
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("pre_stall_wb_en", 160'(wb_en), 160'd1);
        check("pre_stall_wb_addr", 160'(wb_addr), 160'd11);
        check("pre_stall_occ", 160'(occupancy), 160'd4);
        stall = 1'b1;
        issue(1'b1, 7'd20, 4'd1, 1'b1, 128'd20);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall_wb_en_%0d", c), 160'(wb_en), 160'd0);
            check($sformatf("stall_wb_addr_%0d", c), 160'(wb_addr), 160'd11);
            check($sformatf("stall_wb_data_%0d", c), 160'(wb_data), 160'd11);
            check($sformatf("stall_occ_%0d", c), 160'(occupancy), 160'd4);
            for (int k = 1; k <= DEPTH; k++) begin
                check($sformatf("stall_v_c%0d_s%0d", c, k), 160'(stg_valid(k)),
                      160'(k >= 4));
                if (k >= 4)
                    check($sformatf("stall_dst_c%0d_s%0d", c, k), 160'(stg_dst(k)),
                          160'(19 - k));
            end
        end
        stall = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            check($sformatf("resume_wb_en_%0d", j), 160'(wb_en), 160'd1);
            check($sformatf("resume_wb_addr_%0d", j), 160'(wb_addr), 160'(12 + j));
            check($sformatf("resume_occ_%0d", j), 160'(occupancy), 160'(3 - j));
        end
        step();
        check("resume_done", 160'(wb_en), 160'd0);

        // Flush kills the captured instruction
        begin
            int n;
            flush = 1'b1;
            issue(1'b1, 7'd30, 4'd1, 1'b1, 128'd30);
            step();
            flush = 1'b0;
            in_valid = 1'b0;
            check("flush_s1_valid", 160'(stg_valid(1)), 160'd0);
            check("flush_fwd", 160'(fwd_valid), 160'd0);
            check("flush_occ", 160'(occupancy), 160'd0);
            n = 0;
            repeat (8) begin
                step();
                if (wb_en) n++;
            end
            check("flush_no_wb", 160'(n), 160'd0);
        end

        // Flush together with stall leaves the pipe unchanged
        issue(1'b1, 7'd31, 4'd1, 1'b1, 128'd31);
        step();
        in_valid = 1'b0;
        check("fs_pre_valid", 160'(stg_valid(1)), 160'd1);
        check("fs_pre_fwd", 160'(fwd_valid), 160'd1);
        stall = 1'b1;
        flush = 1'b1;
        issue(1'b1, 7'd32, 4'd1, 1'b1, 128'd32);
        step();
        check("fs_s1_valid", 160'(stg_valid(1)), 160'd1);
        check("fs_s1_dst", 160'(stg_dst(1)), 160'd31);
        check("fs_s2_valid", 160'(stg_valid(2)), 160'd0);
        check("fs_occ", 160'(occupancy), 160'd1);
        stall = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (6) step();
        check("fs_wb_early", 160'(wb_en), 160'd0);
        step();
        check("fs_wb_en", 160'(wb_en), 160'd1);
        check("fs_wb_addr", 160'(wb_addr), 160'd31);

        // Latency 0 passes through and is eligible at stage 1
        issue(1'b1, 7'd40, 4'd0, 1'b1, 128'd40);
        step();
        in_valid = 1'b0;
        check("lat0_fwd", 160'(fwd_valid), 160'd1);
        check("lat0_field", 160'(stg_lat(1)), 160'd0);
`ifdef EXEC_RESULT_PIPE_LATCHK_EN
        check("lat0_err", 160'(lat_err), 160'd1);
`endif
        // Non-writing instruction: never forward-eligible, no writeback
        begin
            int n;
            int a;
            issue(1'b1, 7'd41, 4'd1, 1'b0, 128'd41);
            step();
            in_valid = 1'b0;
            check("nowr_fwd", 160'(fwd_valid), 160'b10);
            n = 0;
            a = 0;
            repeat (8) begin
                step();
                if (wb_en) begin
                    n++;
                    a = int'(wb_addr);
                end
            end
            check("nowr_wb_count", 160'(n), 160'd1);
            check("nowr_wb_addr", 160'(a), 160'd40);
        end

        // Reset with 5 entries in flight
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 7'(50 + i), 4'd1, 1'b1, 128'(50 + i));
            step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_pack", 160'(|stage_pack), 160'd0);
        check("mid_rst_fwd", 160'(fwd_valid), 160'd0);
        check("mid_rst_wb_en", 160'(wb_en), 160'd0);
        check("mid_rst_wb_addr", 160'(wb_addr), 160'd0);
        check("mid_rst_wb_data", 160'(wb_data), 160'd0);
        check("mid_rst_occ", 160'(occupancy), 160'd0);
`ifdef EXEC_RESULT_PIPE_LATCHK_EN
        check("mid_rst_lat_err", 160'(lat_err), 160'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            int n;
            n = 0;
            repeat (10) begin
                step();
                if (wb_en) n++;
            end
            check("post_rst_no_wb", 160'(n), 160'd0);
        end

        // Out-of-range latency
        issue(1'b1, 7'd60, 4'd9, 1'b1, 128'd60);
        step();
        in_valid = 1'b0;
`ifdef EXEC_RESULT_PIPE_LATCHK_EN
        check("lat9_err_set", 160'(lat_err), 160'd1);
        repeat (3) step();
        check("lat9_err_sticky", 160'(lat_err), 160'd1);
        rst = 1'b1;
        #1;
        check("lat9_err_cleared", 160'(lat_err), 160'd0);
        rst = 1'b0;
`else
        check("lat9_occ", 160'(occupancy), 160'd1);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exec_result_pipe.md
EXEC_RESULT_PIPE -- requirements
Module: exec_result_pipe

Interface
REQ-001 SHALL have parameters: DEPTH (default 7) = stage count, 2..15; DATA_W (default 128) = result width; REG_ADDR_W (default 7) = register address width; UNIT_W (default 3) = unit id width; LAT_W (default 4) = latency field width.
REQ-002 SHALL have ports, clock and reset first; rst is asynchronous, active-high, and clk is the clock:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  issue slot holds an instruction
- in_unit_id  in  UNIT_W  producing unit
- in_result  in  DATA_W  result value
- in_reg_dst  in  REG_ADDR_W  destination register
- in_latency  in  LAT_W  result-ready stage, 1..DEPTH
- in_reg_wr  in  1  instruction writes the register file
- stall  in  1  freeze the whole pipe
- flush  in  1  kill the instruction being captured this cycle
- stage_pack  out  DEPTH*PACK_W  flat per-stage packets, stage 1 at the MSB end
- fwd_valid  out  DEPTH  per-stage forward-eligible flags
- wb_en  out  1  writeback enable
- wb_addr  out  REG_ADDR_W  writeback address
- wb_data  out  DATA_W  writeback data
- occupancy  out  LAT_W  count of valid stages
- lat_err  out  1  sticky latency error (present only under the macro)

Function
REQ-003 SHALL pack each stage as {valid, unit_id, result, reg_dst, latency, reg_wr}; PACK_W = 2+UNIT_W+DATA_W+REG_ADDR_W+LAT_W.
REQ-004 SHALL, on a clk edge with stall=0, capture the input packet into stage 1 and shift stage k into stage k+1 for k = 1..DEPTH-1.
REQ-005 SHALL set the stage-1 valid bit to in_valid & ~flush at capture; all other fields are captured unconditionally.
REQ-006 SHALL, while stall=1, hold every stage, hold occupancy, and drive wb_en=0 on the next edge; wb_addr and wb_data hold.
REQ-007 SHALL compute fwd_valid[k] combinationally as valid_k & reg_wr_k & (k >= latency_k), with k 1-indexed.
REQ-008 SHALL, on each unstalled edge, register from stage DEPTH: wb_en <= valid & reg_wr, wb_addr <= reg_dst, wb_data <= result. The result is therefore written back DEPTH+1 edges after capture.
REQ-009 SHALL update occupancy on each unstalled edge as occupancy + (captured valid) - (stage DEPTH valid), saturating in the range 0..DEPTH.
REQ-010 SHALL, when stall and flush are asserted together, let stall win: nothing is captured and the pipe state is unchanged.
REQ-011 SHALL treat in_valid=0 as a bubble: the stage is invalid, fwd_valid=0, and no writeback is generated.
REQ-012 SHALL pass in_latency=0 through unmodified; REQ-007 then makes the entry eligible at stage 1.

Reset
REQ-013 SHALL, on rst, asynchronously clear all stage packets, fwd_valid, wb_en, wb_addr, wb_data, occupancy and lat_err to 0.
REQ-014 SHALL discard in-flight entries when rst is asserted mid-operation; no writeback occurs for them after reset is released.

Configuration
REQ-015 SHALL, with EXEC_RESULT_PIPE_LATCHK_EN defined, set lat_err on any unstalled capture where in_valid=1 and in_latency is 0 or greater than DEPTH; lat_err stays set until rst.
REQ-016 SHALL, without EXEC_RESULT_PIPE_LATCHK_EN, omit the lat_err port and its logic entirely.

Structure
REQ-017 SHALL take the field offsets of the PACK_W layout and the unit id constants (PERM=3'b100, LS=3'b101, BRANCH=3'b110) from the shared opcode package.
REQ-018 SHALL implement one sub-module, exec_pipe_stage, which is a single stall-able packet register instantiated DEPTH times through a generate loop.

Verification
REQ-019 Single issue: valid, reg_dst=5, result=0xA5..A5, latency=3, reg_wr=1 -> fwd_valid[1..2]=0, fwd_valid[3..7]=1; wb_en=1, wb_addr=5, wb_data=0xA5..A5 on the 8th edge after capture.
REQ-020 Back-to-back issue of 7 valid instructions -> occupancy reads 1,2,..,7 and then holds at 7 while issue continues.
REQ-021 Stall held for 3 cycles with 4 entries in flight -> stage_pack and occupancy unchanged, wb_en=0; after release, writebacks resume in order with no loss.
REQ-022 Flush with in_valid=1 -> stage-1 valid=0, no writeback DEPTH+1 edges later; flush together with stall -> no state change.
REQ-023 rst asserted while 5 entries are in flight -> all outputs 0 immediately; no wb_en pulses for 10 cycles after rst deasserts with in_valid=0.
REQ-024 With the macro defined, issue latency=9 at DEPTH=7 -> lat_err=1 and stays 1 until rst; without the macro, the same stimulus compiles cleanly with no lat_err port.
